// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the MEM-stage load/store unit.
// Used by lsu_mem_stage and lsu_lane_align.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_CAP   = 3'd2,
        ST_MERGE = 3'd3,
        ST_WR    = 3'd4
    } lsu_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic is_subword(input logic [1:0] size);
        return (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

    // Size 2'b11 is handled as a word, so it shares the word alignment rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            default: return lo != 2'b00;
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] lane);
        return word[8*lane +: 8];
    endfunction

    function automatic logic [15:0] half_sel(input logic [31:0] word, input logic hi);
        return hi ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: little-endian load extract with sign/zero extension,
// and sub-word store merge into a previously read memory word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = byte_sel(word, addr_lo);
        lane_half = half_sel(word, addr_lo[1]);
        load_data = word;
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & lane_byte[7]}}, lane_byte};
            SZ_HALF: load_data = {{16{~is_unsigned & lane_half[15]}}, lane_half};
            default: load_data = word;
        endcase
    end

    // Each byte lane independently picks store data or keeps the old memory byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic hit_byte;
            logic hit_half;
            assign hit_byte = (size == SZ_BYTE) && (addr_lo == LANE);
            assign hit_half = (size == SZ_HALF) && (addr_lo[1] == LANE[1]);
            assign merge_data[8*gi +: 8] =
                hit_byte          ? store_data[7:0] :
                hit_half          ? store_data[8*(gi%2) +: 8] :
                is_subword(size)  ? word[8*gi +: 8] :
                                    store_data[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: whole-word memory accesses, RMW for sub-word stores.
// Optional misaligned-access trap when LSU_MISALIGN_TRAP_EN is defined.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_writeData,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    input  logic [31:0]       mem_readdata
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic              misalign
`endif
);

    lsu_state_t        state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              we_reg;
    logic [1:0]        size_reg;
    logic              uns_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       wbuf_reg;
    logic              resp_valid_reg;
    logic [31:0]       resp_rdata_reg;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;
    logic              trap_accept;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_reg;
    assign trap_accept = is_misaligned(req_size, req_addr[1:0]);
    assign misalign    = misalign_reg;
`else
    assign trap_accept = 1'b0;
`endif

    lsu_lane_align u_lane_align (
        .word        (mem_readdata),
        .addr_lo     (addr_reg[1:0]),
        .size        (size_reg),
        .is_unsigned (uns_reg),
        .store_data  (wdata_reg),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    // Strobes decode straight from state so an async reset drops them at once.
    assign req_ready     = (state_reg == ST_IDLE);
    assign mem_memRead   = (state_reg == ST_RD);
    assign mem_memWrite  = (state_reg == ST_WR);
    assign mem_address   = {addr_reg[ADDR_W-1:2], 2'b00};
    assign mem_writeData = wbuf_reg;
    assign resp_valid    = resp_valid_reg;
    assign resp_rdata    = resp_rdata_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            we_reg         <= 1'b0;
            size_reg       <= 2'b00;
            uns_reg        <= 1'b0;
            wdata_reg      <= '0;
            wbuf_reg       <= '0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_reg   <= 1'b0;
`endif
        end else begin
            resp_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_reg  <= req_addr;
                        we_reg    <= req_we;
                        size_reg  <= req_size;
                        uns_reg   <= req_unsigned;
                        wdata_reg <= req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                        misalign_reg <= trap_accept;
`endif
                        if (trap_accept) begin
                            resp_valid_reg <= 1'b1;
                        end else if (req_we && !is_subword(req_size)) begin
                            wbuf_reg  <= req_wdata;
                            state_reg <= ST_WR;
                        end else begin
                            state_reg <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    state_reg <= we_reg ? ST_MERGE : ST_CAP;
                end
                ST_CAP: begin
                    resp_rdata_reg <= load_data;
                    resp_valid_reg <= 1'b1;
                    state_reg      <= ST_IDLE;
                end
                ST_MERGE: begin
                    wbuf_reg  <= merge_data;
                    state_reg <= ST_WR;
                end
                ST_WR: begin
                    resp_valid_reg <= 1'b1;
                    state_reg      <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed scenarios then random traffic against a
// byte-array memory model. Honors LSU_MISALIGN_TRAP_EN when defined.
module tb_lsu_mem_stage;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [31:0] mem_address;
    logic [31:0] mem_writeData;
    logic        mem_memRead;
    logic        mem_memWrite;
    logic [31:0] mem_readdata = '0;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    always #5 clk = ~clk;

    lsu_mem_stage #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_memRead   (mem_memRead),
        .mem_memWrite  (mem_memWrite),
        .mem_readdata  (mem_readdata)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .misalign      (misalign)
`endif
    );

    // Environment memory: 16 words, read data appears the cycle after the read edge.
    logic [31:0] tb_mem [16] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_memRead)  mem_readdata <= tb_mem[mem_address[5:2]];
        if (mem_memWrite) tb_mem[mem_address[5:2]] <= mem_writeData;
    end

    int both_cnt = 0;
    always @(negedge clk) if (mem_memRead && mem_memWrite) both_cnt++;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    logic [7:0]  ref_bytes [64];
    logic [31:0] model_rdata;
    logic [31:0] last_rdata;
    logic        last_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input int ea, input int n, input logic uns);
        longint v;
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_bytes[ea + i]) << (8 * i);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_word(input int w);
        return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
    endfunction

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic mis,
                          output int lat, output int rd_c, output int wr_c);
        int guard;
        rd_c = 0; wr_c = 0; lat = 0; mis = 1'b0; rdata = '0;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (1) begin
            @(negedge clk);
            if (mem_memRead)  rd_c++;
            if (mem_memWrite) wr_c++;
            if (resp_valid) break;
            if (lat >= 12) begin
                lat = 99;
                break;
            end
            @(posedge clk);
            lat++;
        end
        rdata = resp_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = misalign;
`endif
    endtask

    task automatic xact(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
        int n, ea, exp_lat, exp_rd, exp_wr, lat, rc, wc;
        logic trap;
        logic [31:0] rd;
        logic mis;
        n = nbytes(sz);
        ea = int'(addr) & ~(n - 1);
        trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (int'(addr) % n) != 0;
`endif
        if (trap) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!we) begin
            model_rdata = model_load(ea, n, uns);
            exp_lat = 3; exp_rd = 1; exp_wr = 0;
        end else begin
            for (int i = 0; i < n; i++) ref_bytes[ea + i] = wd[8*i +: 8];
            exp_lat = (n == 4) ? 2 : 4;
            exp_rd  = (n == 4) ? 0 : 1;
            exp_wr  = 1;
        end
        do_req(we, sz, uns, addr, wd, rd, mis, lat, rc, wc);
        $display("[%0t] %s we=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h mis=%0d lat=%0d rd=%0d wr=%0d",
                 $time, tag, we, sz, uns, addr, wd, rd, mis, lat, rc, wc);
        check({tag, "_lat"},   32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, rd, model_rdata);
        check({tag, "_rdstb"}, 32'(rc), 32'(exp_rd));
        check({tag, "_wrstb"}, 32'(wc), 32'(exp_wr));
        check({tag, "_mis"},   32'(mis), 32'(trap));
        last_rdata = rd;
        last_mis   = mis;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, rsp;
        for (int i = 0; i < 64; i++) ref_bytes[i] = 8'h00;
        model_rdata = '0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready",  32'(req_ready), 32'd1);
        check("rst_rvalid", 32'(resp_valid), 32'd0);
        check("rst_rdata",  resp_rdata, 32'h0);
        check("rst_wdata",  mem_writeData, 32'h0);
        check("rst_addr",   mem_address, 32'h0);
        check("rst_strobe", 32'({mem_memRead, mem_memWrite}), 32'd0);

        // Word store then word load
        xact("t1_st", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
        xact("t1_ld", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        check("t1_const", last_rdata, 32'hDEADBEEF);

        // Byte store RMW and signed/unsigned byte loads
        xact("t2_init", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344);
        xact("t2_sb",   1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h000000A5);
        check("t2_mem", tb_mem[4], 32'h1122A544);
        xact("t2_lbs",  1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0);
        check("t2_lbs_const", last_rdata, 32'hFFFFFFA5);
        xact("t2_lbu",  1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0);
        check("t2_lbu_const", last_rdata, 32'h000000A5);

        // Half store RMW and half loads
        xact("t3_sh",  1'b1, SZ_HALF, 1'b0, 32'h12, 32'h00008001);
        check("t3_mem", tb_mem[4], 32'h8001A544);
        xact("t3_lhs", 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0);
        check("t3_lhs_const", last_rdata, 32'hFFFF8001);
        xact("t3_lhu", 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0);
        check("t3_lhu_const", last_rdata, 32'h00008001);

        // req_valid held for 6 edges: a 3-edge load can be accepted only twice
        @(negedge clk);
        req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 32'h10;
        req_valid = 1'b1;
        acc = 0; rsp = 0;
        for (int i = 0; i < 6; i++) begin
            if (req_ready) acc++;
            @(posedge clk);
            @(negedge clk);
            if (resp_valid) rsp++;
        end
        req_valid = 1'b0;
        model_rdata = model_load(16, 4, 1'b0);
        $display("[%0t] t4_hold accepts=%0d responses=%0d rdata=%h", $time, acc, rsp, resp_rdata);
        check("t4_accepts", 32'(acc), 32'd2);
        check("t4_resps",   32'(rsp), 32'd2);
        check("t4_rdata",   resp_rdata, model_rdata);

        // Reset during MERGE of a byte store
        @(negedge clk);
        req_we = 1'b1; req_size = SZ_BYTE; req_unsigned = 1'b0; req_addr = 32'h10;
        req_wdata = 32'h0000005A; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("t5_rd_phase", 32'(mem_memRead), 32'd1);
        @(negedge clk);
        check("t5_merge_phase", 32'({req_ready, mem_memRead, mem_memWrite}), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t5_strobes_drop", 32'({mem_memRead, mem_memWrite}), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("t5_no_resp", 32'({resp_valid, mem_memWrite}), 32'd0);
        end
        rst_n = 1'b1;
        model_rdata = '0;
        $display("[%0t] t5_reset mem[0x10]=%h rdata=%h", $time, tb_mem[4], resp_rdata);
        check("t5_rdata_cleared", resp_rdata, 32'h0);
        check("t5_mem_intact", tb_mem[4], model_word(4));
        xact("t5_ld", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        check("t5_old_word", last_rdata, 32'h8001A544);

        // Misaligned word load
        xact("t6_ld13", 1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("t6_trap", 32'(last_mis), 32'd1);
`else
        check("t6_word", last_rdata, 32'h8001A544);
`endif

        for (int k = 0; k < 60; k++) begin
            xact("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
        end

        for (int w = 0; w < 16; w++) check("final_mem", tb_mem[w], model_word(w));
        check("never_both_strobes", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
